// File: rtl/lcd_reader.sv
// HD44780-style read sequencer: drives RS/RW/E for data or busy-flag reads and
// captures the LCD data bus at the end of the E pulse, optionally polling BF.
module lcd_reader #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 12,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned POLL_MAX     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       rs,
  input  logic       poll,
  output logic       busy,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       timeout,
  input  logic [7:0] lcd_data_in,
  output logic [1:0] lcd_ctrl,
  output logic       lcd_enable
);

  localparam int unsigned MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned ATT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic               poll_q, poll_d;
  logic [7:0]         cap_q, cap_d;
  logic               busy_q, busy_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               en_q, en_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      att_q     <= '0;
      poll_q    <= 1'b0;
      cap_q     <= '0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      timeout_q <= 1'b0;
      ctrl_q    <= 2'b00;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      att_q     <= att_d;
      poll_q    <= poll_d;
      cap_q     <= cap_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      timeout_q <= timeout_d;
      ctrl_q    <= ctrl_d;
      en_q      <= en_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    att_d     = att_q;
    poll_d    = poll_q;
    cap_d     = cap_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    timeout_d = timeout_q;
    ctrl_d    = ctrl_q;
    en_d      = en_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          poll_d  = poll;
          ctrl_d  = {(poll ? 1'b0 : rs), 1'b1};
          busy_d  = 1'b1;
          att_d   = ATT_W'(1);
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          en_d    = 1'b1;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        // Sample the bus on the falling-E edge: value of the last E-high cycle
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cap_d   = lcd_data_in;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          if (poll_q && cap_q[7] && (att_q < ATT_W'(POLL_MAX))) begin
            att_d   = att_q + ATT_W'(1);
            cnt_d   = CNT_W'(SETUP_CYCLES - 1);
            state_d = ST_SETUP;
          end else begin
            rdata_d   = cap_q;
            rvalid_d  = 1'b1;
            timeout_d = poll_q & cap_q[7];
            ctrl_d    = 2'b00;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign timeout    = timeout_q;
  assign lcd_ctrl   = ctrl_q;
  assign lcd_enable = en_q;

endmodule
